// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer and related input stages.
//   db_state_e        : debouncer FSM state (2-bit, fixed encodings)
//   DEF_STABLE_CYCLES : default stable-window length in clock cycles
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the
// clk domain. Both flops load RESET_VAL under synchronous reset.
//   clk   : destination clock
//   reset : synchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input (button/switch). The input is first
// synchronised, then an FSM requires STABLE_CYCLES consecutive samples at
// the new level before the clean output follows. One-cycle strobes mark
// each accepted rising and falling transition. All outputs are registered.
//   clk          : system clock
//   reset        : synchronous, active-high
//   rawIn        : asynchronous raw input, may bounce
//   debouncedOut : clean level
//   riseStrobe   : one cycle high when debouncedOut goes 0->1
//   fallStrobe   : one cycle high when debouncedOut goes 1->0
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,  // must be >= 2
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic rawIn,
  output logic debouncedOut,
  output logic riseStrobe,
  output logic fallStrobe
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam db_state_e      RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync_q;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, rise_nxt, fall_nxt;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rawIn),
    .q     (sync_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_STATE;
      cnt          <= '0;
      debouncedOut <= RESET_LEVEL;
      riseStrobe   <= 1'b0;
      fallStrobe   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      debouncedOut <= out_nxt;
      riseStrobe   <= rise_nxt;
      fallStrobe   <= fall_nxt;
    end
  end

  // The first sample at the new level counts as 1, so the output flips on
  // the STABLE_CYCLES-th consecutive sample. Any sample back at the old
  // level returns to the stable state and clears the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = debouncedOut;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (sync_q) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_q) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          out_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_q) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_q) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (STABLE_CYCLES=4, RESET_LEVEL=0).
// Stimulus pushes the expected strobe events (edge number + kind) into a
// queue; a negedge monitor pops and checks them whenever a strobe appears,
// and also checks level, exclusivity and reset behaviour every cycle.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int   SC     = 4;
  localparam logic RST_LV = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rawIn = 1'b1;
  logic debouncedOut, riseStrobe, fallStrobe;

  always #5 clk = ~clk;

  input_debouncer #(
    .STABLE_CYCLES (SC),
    .RESET_LEVEL   (RST_LV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rawIn        (rawIn),
    .debouncedOut (debouncedOut),
    .riseStrobe   (riseStrobe),
    .fallStrobe   (fallStrobe)
  );

  // cyc = number of rising edges so far; rst_q = reset as sampled by the last edge
  int   cyc   = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  typedef struct {
    int at_edge;
    bit rise;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  ev;
  logic exp_lvl = RST_LV;
  int   n_chk   = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input int at, input bit r);
    ev_t e;
    e.at_edge = at;
    e.rise    = r;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_out",   debouncedOut, RST_LV);
        chk("rst_rise",  riseStrobe,   0);
        chk("rst_fall",  fallStrobe,   0);
        chk("rst_state", dut.state,    STABLE_LO);
        exp_lvl = RST_LV;
      end else begin
        chk("strobe_excl", riseStrobe & fallStrobe, 0);
        if (riseStrobe || fallStrobe) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {riseStrobe, fallStrobe}, 0);
          end else begin
            ev = exp_q.pop_front();
            chk("strobe_edge", cyc,        ev.at_edge);
            chk("strobe_rise", riseStrobe, ev.rise);
            chk("strobe_fall", fallStrobe, !ev.rise);
            exp_lvl = ev.rise;
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].at_edge) begin
          chk("missing_strobe", cyc, exp_q[0].at_edge);
          ev = exp_q.pop_front();
        end
        chk("level", debouncedOut, exp_lvl);
      end
    end
  end

  // Stimulus. A level set right after edge c is first sampled at edge c+1;
  // the output then changes at edge c+1+1+SC = c+6.
  initial begin
    reset = 1'b1; rawIn = 1'b1;
    step(3);                            // three reset edges with rawIn high
    reset = 1'b0; rawIn = 1'b0;
    step(4);

    // clean rise
    rawIn = 1'b1; expect_ev(cyc + 6, 1'b1);
    step(10);

    // clean fall
    rawIn = 1'b0; expect_ev(cyc + 6, 1'b0);
    step(10);

    // bounce: 3 high / 1 low, five times -> nothing
    repeat (5) begin
      rawIn = 1'b1; step(3);
      rawIn = 1'b0; step(1);
    end

    // settle high after bounce -> exactly one rise
    rawIn = 1'b1; expect_ev(cyc + 6, 1'b1);
    step(10);

    // return low
    rawIn = 1'b0; expect_ev(cyc + 6, 1'b0);
    step(10);

    // reset mid-WAIT: pre-reset count must not carry over
    rawIn = 1'b1; step(3);
    reset = 1'b1; step(1);
    reset = 1'b0; expect_ev(cyc + 6, 1'b1);
    step(14);

    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      chk("missing_strobe_end", 0, ev.at_edge);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
